bcd_countdown_timer: RTL
========================

BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Interface
REQ-001 Parameter TICK_DIV, default 50000000: CLOCK_50 cycles per count step; legal range 2 and up.
REQ-002 CLOCK_50  in  1  system clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 load  in  1  single-cycle pulse; copies preset_tens/preset_ones into the count.
REQ-005 preset_tens  in  4  BCD tens digit for load.
REQ-006 preset_ones  in  4  BCD ones digit for load.
REQ-007 start  in  1  single-cycle pulse; begins or resumes the countdown.
REQ-008 pause  in  1  single-cycle pulse; suspends the countdown.
REQ-009 count_tens  out  4  current tens digit, BCD.
REQ-010 count_ones  out  4  current ones digit, BCD.
REQ-011 HEX0  out  7 [0:6]  active-low seven-segment pattern for count_ones.
REQ-012 HEX1  out  7 [0:6]  active-low seven-segment pattern for count_tens.
REQ-013 running  out  1  high while the FSM is in RUN.
REQ-014 done  out  1  high while the FSM is in DONE.

Function
REQ-015 The FSM SHALL have four states: IDLE, RUN, PAUSED and DONE; running and done are decoded from the state register.
REQ-016 Input priority SHALL be reset > load > start/pause.
REQ-017 load, in any state:
- next state IDLE
- count = preset, with each digit >9 clamped to 9
- tick counter cleared.
REQ-018 IDLE + start:
- count != 00 -> RUN, tick counter cleared
- count == 00 -> DONE on the next edge.
REQ-019 A free-running tick counter (0..TICK_DIV-1) SHALL advance only in RUN and SHALL hold its value in PAUSED.
REQ-020 In RUN, at the edge where the tick counter equals TICK_DIV-1: the counter wraps to 0 and the count decrements once.
REQ-021 Decrement rule:
- ones > 0 -> ones-1
- ones == 0 -> ones = 9, tens-1
- the result SHALL never leave the range 00..99.
REQ-022 The first decrement SHALL occur exactly TICK_DIV edges after the edge that accepted start.
REQ-023 A decrement that produces 00 SHALL move the FSM to DONE on the same edge; done rises together with count 00.
REQ-024 RUN + pause -> PAUSED; if pause coincides with a tick, the decrement happens first (or DONE is entered if the count reaches 00, in which case pause is ignored).
REQ-025 PAUSED + start -> RUN; the tick phase resumes from the held value, so no partial period is lost.
REQ-026 Ignored pulses:
- pause in IDLE, PAUSED or DONE
- start in RUN or DONE
- start together with pause in PAUSED -> resume.
REQ-027 DONE SHALL hold count 00 and done=1 until load or reset.
REQ-028 HEX0/HEX1 SHALL be combinational decodes of the count registers (zero latency), bit 0 = segment a, using the team table: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100, any other value = 1111111.

Reset
REQ-029 On reset: state IDLE, count 00, tick counter 0, running=0, done=0, HEX0=HEX1=0000001.
REQ-030 Reset asserted mid-RUN or mid-PAUSED SHALL abort immediately, with no further decrement, and load/start in the same cycle SHALL be ignored.

Verification (TICK_DIV=4)
REQ-031 reset; load 0/3; start -> count 02 at edge +4, 01 at +8, 00 with done=1 at +12; HEX0 = 1001111 while count = 01.
REQ-032 load 1/0; start -> after 4 edges count 09 (tens 0, ones 9), HEX1=0000001, HEX0=0001100.
REQ-033 load 0/5; start; pause 2 edges after start; hold 10 cycles; start -> count 04 exactly 2 edges after resume; running low throughout the pause.
REQ-034 load 0/1; start; pause on the same edge as the tick -> count 00, done=1, state DONE (not PAUSED).
REQ-035 load 12/15 (invalid) -> count 99; start at count 00 -> done=1 next edge; start in DONE -> no change.
REQ-036 mid-RUN, reset with load=1 on the same edge -> count 00, running=0, done=0, HEX outputs 0000001.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - two-digit BCD countdown timer with run/pause control and seven-segment outputs
module bcd_countdown_timer #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] preset_tens,
    input  logic [3:0] preset_ones,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] count_tens,
    output logic [3:0] count_ones,
    output logic [0:6] HEX0,
    output logic [0:6] HEX1,
    output logic       running,
    output logic       done
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic [TW-1:0] tick_q, tick_d;

    logic [3:0]    dec_tens, dec_ones;
    logic          dec_zero;
    logic          count_zero;

    function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [0:6] seg7(input logic [3:0] d);
        logic [0:6] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0001100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign count_zero = (tens_q == 4'd0) && (ones_q == 4'd0);

    // Saturates at 00 so the count can never wrap below the legal range.
    always_comb begin
        dec_tens = tens_q;
        dec_ones = ones_q;
        if (ones_q != 4'd0) begin
            dec_ones = ones_q - 4'd1;
        end else if (tens_q != 4'd0) begin
            dec_ones = 4'd9;
            dec_tens = tens_q - 4'd1;
        end
    end

    assign dec_zero = (dec_tens == 4'd0) && (dec_ones == 4'd0);

    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        tick_d  = tick_q;
        if (load) begin
            state_d = IDLE;
            tens_d  = clamp_bcd(preset_tens);
            ones_d  = clamp_bcd(preset_ones);
            tick_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (count_zero) begin
                            state_d = DONE;
                        end else begin
                            state_d = RUN;
                            tick_d  = '0;
                        end
                    end
                end
                RUN: begin
                    // The tick still advances on the pause edge so the held phase loses nothing.
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        tens_d = dec_tens;
                        ones_d = dec_ones;
                        if (dec_zero) begin
                            state_d = DONE;
                        end else if (pause) begin
                            state_d = PAUSED;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                        if (pause) begin
                            state_d = PAUSED;
                        end
                    end
                end
                PAUSED: begin
                    if (start) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            tick_q  <= tick_d;
        end
    end

    assign count_tens = tens_q;
    assign count_ones = ones_q;
    assign HEX0       = seg7(ones_q);
    assign HEX1       = seg7(tens_q);
    assign running    = (state_q == RUN);
    assign done       = (state_q == DONE);

endmodule
